// File: rtl/project_types.sv
// Shared types and constants for the fetch path: address/instruction words,
// ROM chip-enable encodings and the reset fetch address.
package project_types;

   typedef logic [31:0] addr_t;
   typedef logic [31:0] inst_data_t;

   localparam logic       CHIP_ENABLE      = 1'b1;
   localparam logic       CHIP_DISABLE     = 1'b0;
   localparam addr_t      RESET_PC_DEFAULT = 32'h0000_0000;
   localparam addr_t      ZERO_WORD        = 32'h0000_0000;
   localparam inst_data_t NOP_INST         = 32'h0000_0000;

   // Instruction fetches must be word aligned.
   function automatic logic is_misaligned(input addr_t a);
      return a[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/i_fetch_inst.sv
// Instruction-fetch bus between the IF stage (master) and the instruction ROM.
interface i_fetch_inst;

   logic                    en;
   project_types::addr_t    addr;
   project_types::inst_data_t data;

   modport master (output en, output addr, input data);
   modport slave  (input en, input addr, output data);

endinterface

// File: rtl/if_stage_pc_reg.sv
// Program counter with enable-after-reset, next-PC priority mux and a
// pending-branch latch so a redirect arriving during stall_if is not lost.
module pc_reg
   import project_types::*;
#(
   parameter addr_t       RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned PC_STEP  = 4
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  stall_if,
   input  logic  flush,
   input  addr_t flush_pc,
   input  logic  branch_flag,
   input  addr_t branch_target,
   output addr_t pc,
   output logic  en_q
);

   logic  pending_valid;
   addr_t pending_target;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc             <= RESET_PC;
         en_q           <= 1'b0;
         pending_valid  <= 1'b0;
         pending_target <= ZERO_WORD;
      end else begin
         en_q <= 1'b1;
         if (en_q) begin
            if (flush) begin
               pc            <= flush_pc;
               pending_valid <= 1'b0;
            end else if (stall_if) begin
               // Latest redirect seen while stalled is the one applied.
               if (branch_flag) begin
                  pending_valid  <= 1'b1;
                  pending_target <= branch_target;
               end
            end else if (branch_flag) begin
               pc            <= branch_target;
               pending_valid <= 1'b0;
            end else if (pending_valid) begin
               pc            <= pending_target;
               pending_valid <= 1'b0;
            end else begin
               pc <= pc + addr_t'(PC_STEP);
            end
         end
      end
   end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: drives the ROM fetch port from the PC and registers
// {pc, inst} into the IF/ID pipeline register.
module if_stage
   import project_types::*;
#(
   parameter addr_t       RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned PC_STEP  = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       stall_if,
   input  logic       stall_id,
   input  logic       flush,
   input  addr_t      flush_pc,
   input  logic       branch_flag,
   input  addr_t      branch_target,
   output logic       rom_en,
   output addr_t      rom_addr,
   input  inst_data_t rom_data,
   output addr_t      id_pc,
   output inst_data_t id_inst,
   output logic       id_valid,
   output logic       id_exc_adel
);

   addr_t pc;
   logic  en_q;

   pc_reg #(
      .RESET_PC (RESET_PC),
      .PC_STEP  (PC_STEP)
   ) u_pc_reg (
      .clk           (clk),
      .rst           (rst),
      .stall_if      (stall_if),
      .flush         (flush),
      .flush_pc      (flush_pc),
      .branch_flag   (branch_flag),
      .branch_target (branch_target),
      .pc            (pc),
      .en_q          (en_q)
   );

   i_fetch_inst fetch_bus ();

   assign fetch_bus.en   = (en_q && !is_misaligned(pc)) ? CHIP_ENABLE : CHIP_DISABLE;
   assign fetch_bus.addr = pc;
   assign fetch_bus.data = rom_data;

   assign rom_en   = fetch_bus.en;
   assign rom_addr = fetch_bus.addr;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         id_pc       <= ZERO_WORD;
         id_inst     <= NOP_INST;
         id_valid    <= 1'b0;
         id_exc_adel <= 1'b0;
      end else if (stall_id) begin
         id_pc       <= id_pc;
      end else if (stall_if) begin
         // Bubble keeps id_pc so exception reporting still sees the last PC.
         id_inst     <= NOP_INST;
         id_valid    <= 1'b0;
         id_exc_adel <= 1'b0;
      end else begin
         id_pc       <= pc;
         id_inst     <= fetch_bus.data;
         id_valid    <= en_q;
         id_exc_adel <= en_q & is_misaligned(pc);
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Directed-vector bench for if_stage with a combinational ROM model.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_if;
   logic        stall_id;
   logic        flush;
   logic [31:0] flush_pc;
   logic        branch_flag;
   logic [31:0] branch_target;
   logic        rom_en;
   logic [31:0] rom_addr;
   logic [31:0] rom_data;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic        id_valid;
   logic        id_exc_adel;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   if_stage #(
      .RESET_PC (32'h0000_0000),
      .PC_STEP  (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .stall_if      (stall_if),
      .stall_id      (stall_id),
      .flush         (flush),
      .flush_pc      (flush_pc),
      .branch_flag   (branch_flag),
      .branch_target (branch_target),
      .rom_en        (rom_en),
      .rom_addr      (rom_addr),
      .rom_data      (rom_data),
      .id_pc         (id_pc),
      .id_inst       (id_inst),
      .id_valid      (id_valid),
      .id_exc_adel   (id_exc_adel)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return 32'hC000_0000 ^ a;
   endfunction

   always_comb rom_data = rom_en ? rom_word(rom_addr) : 32'h0;

   always @(negedge clk) begin
      if (!rst)
         assert (!(stall_id && !stall_if))
            else $error("illegal stall_id without stall_if");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_id(input string tag, input logic [31:0] pc_e,
                           input logic [31:0] inst_e, input logic valid_e);
      check({tag, ".id_pc"},    id_pc,          pc_e);
      check({tag, ".id_inst"},  id_inst,        inst_e);
      check({tag, ".id_valid"}, 32'(id_valid),  32'(valid_e));
   endtask

   initial begin
      rst = 1'b1; stall_if = 1'b0; stall_id = 1'b0; flush = 1'b0;
      flush_pc = '0; branch_flag = 1'b0; branch_target = '0;

      // Reset release
      repeat (3) tick();
      check("rst.rom_en", 32'(rom_en), 32'd0);
      check("rst.rom_addr", rom_addr, 32'h0);
      check("rst.adel", 32'(id_exc_adel), 32'd0);
      check_id("rst", 32'h0, 32'h0, 1'b0);
      rst = 1'b0;
      #1;
      check("rel0.rom_en", 32'(rom_en), 32'd0);
      tick();
      check("rel1.rom_en", 32'(rom_en), 32'd1);
      check("rel1.rom_addr", rom_addr, 32'h0);
      check("rel1.id_valid", 32'(id_valid), 32'd0);
      tick();
      check("seq4.rom_addr", rom_addr, 32'h4);
      check_id("seq4", 32'h0, rom_word(32'h0), 1'b1);
      tick();
      check("seq8.rom_addr", rom_addr, 32'h8);
      check("seq8.id_pc", id_pc, 32'h4);
      tick();
      check("seqC.rom_addr", rom_addr, 32'hC);
      tick();
      check("seq10.rom_addr", rom_addr, 32'h10);
      check("seq10.id_pc", id_pc, 32'hC);

      // Branch with delay slot at pc=0x10
      branch_flag = 1'b1; branch_target = 32'h40;
      tick();
      branch_flag = 1'b0;
      check("br.rom_addr", rom_addr, 32'h40);
      check_id("br.slot", 32'h10, rom_word(32'h10), 1'b1);
      tick();
      check("br2.rom_addr", rom_addr, 32'h44);
      check_id("br2", 32'h40, rom_word(32'h40), 1'b1);

      // Stall bubble with pending branch
      stall_if = 1'b1; branch_flag = 1'b1; branch_target = 32'h80;
      tick();
      branch_flag = 1'b0;
      check("st1.rom_addr", rom_addr, 32'h44);
      check_id("st1", 32'h40, 32'h0, 1'b0);
      tick();
      stall_if = 1'b0;
      check("st2.rom_addr", rom_addr, 32'h44);
      check("st2.id_valid", 32'(id_valid), 32'd0);
      tick();
      check("pend.rom_addr", rom_addr, 32'h80);
      check_id("pend", 32'h44, rom_word(32'h44), 1'b1);
      tick();
      check("pend2.rom_addr", rom_addr, 32'h84);
      check_id("pend2", 32'h80, rom_word(32'h80), 1'b1);

      // Full stall
      stall_if = 1'b1; stall_id = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("fst.rom_addr", rom_addr, 32'h84);
         check_id("fst", 32'h80, rom_word(32'h80), 1'b1);
      end
      stall_if = 1'b0; stall_id = 1'b0;
      tick();
      check("fst.resume", rom_addr, 32'h88);
      check_id("fst.resume", 32'h84, rom_word(32'h84), 1'b1);

      // Flush beats branch and stall
      flush = 1'b1; flush_pc = 32'h180; branch_flag = 1'b1;
      branch_target = 32'h40; stall_if = 1'b1;
      tick();
      flush = 1'b0; branch_flag = 1'b0; stall_if = 1'b0;
      check("fl.rom_addr", rom_addr, 32'h180);
      check_id("fl", 32'h0, 32'h0, 1'b0);
      tick();
      check("fl.nopend", rom_addr, 32'h184);
      check_id("fl2", 32'h180, rom_word(32'h180), 1'b1);

      // Misaligned fetch
      flush = 1'b1; flush_pc = 32'h102;
      tick();
      flush = 1'b0;
      check("mis.rom_en", 32'(rom_en), 32'd0);
      check("mis.rom_addr", rom_addr, 32'h102);
      tick();
      check("mis.adel", 32'(id_exc_adel), 32'd1);
      check_id("mis", 32'h102, 32'h0, 1'b1);
      check("mis.next", rom_addr, 32'h106);

      // Wrap at top of address space
      flush = 1'b1; flush_pc = 32'hFFFF_FFFC;
      tick();
      flush = 1'b0;
      check("wrap.rom_en", 32'(rom_en), 32'd1);
      check("wrap.adel_clr", 32'(id_exc_adel), 32'd0);
      tick();
      check("wrap.rom_addr", rom_addr, 32'h0);
      check_id("wrap", 32'hFFFF_FFFC, rom_word(32'hFFFF_FFFC), 1'b1);

      // Reset drops a pending branch
      stall_if = 1'b1; branch_flag = 1'b1; branch_target = 32'h200;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0; stall_if = 1'b0; branch_flag = 1'b0;
      check("rpend.rom_addr", rom_addr, 32'h0);
      check("rpend.id_valid", 32'(id_valid), 32'd0);
      tick();
      check("rpend1.rom_addr", rom_addr, 32'h0);
      tick();
      check("rpend2.rom_addr", rom_addr, 32'h4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
